// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential fetch stage with 2-entry skid buffer.
// Optional perf counters: define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int         INSTR_WIDTH = 32,
  parameter int         DEPTH       = 256,
  parameter logic [5:0] HALT_OP     = 6'h3F,
  localparam int        AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AW-1:0]          start_addr,
  input  logic                   stop,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_addr,
  output logic [AW-1:0]          rd_addr,
  input  logic [INSTR_WIDTH-1:0] rd_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [AW-1:0]          instr_pc,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            instr_count,
  output logic [31:0]            stall_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                 state;
  logic [AW-1:0]          pc;
  logic                   s1_v;
  logic                   s2_v;
  logic [AW-1:0]          s2_pc;
  logic [1:0]             cnt;
  logic [INSTR_WIDTH-1:0] b1_data;
  logic [AW-1:0]          b1_pc;

  logic       pop;
  logic       cap;
  logic       halt;
  logic       issue;
  logic [1:0] cnt_ap;
  logic [2:0] load;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] a
  );
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // The sync memory's output register is the third storage slot:
  // rd_addr is held whenever no new read issues, so an uncaptured
  // word stays on rd_data until the buffer has room for it.
  assign pop    = instr_valid & instr_ready;
  assign cnt_ap = cnt - {1'b0, pop};
  assign cap    = s2_v & (cnt_ap != 2'd2);
  assign halt   = cap &
                  (rd_data[INSTR_WIDTH-1 -: 6] == HALT_OP);
  assign load   = {1'b0, cnt_ap} + {2'b0, s1_v} + {2'b0, s2_v};
  assign issue  = (state == RUN) & ~halt & (load <= 3'd2);

  assign instr_valid = (cnt != 2'd0);
  assign busy        = (state != IDLE);

  // Control FSM, read issue, read pipeline and skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      rd_addr    <= '0;
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s2_pc      <= '0;
      cnt        <= 2'd0;
      instr_data <= '0;
      instr_pc   <= '0;
      b1_data    <= '0;
      b1_pc      <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        cnt   <= 2'd0;
        s1_v  <= 1'b0;
        s2_v  <= 1'b0;
      end else if (redirect_valid && state != IDLE) begin
        state   <= RUN;
        cnt     <= 2'd0;
        s2_v    <= 1'b0;
        s1_v    <= 1'b1;
        rd_addr <= redirect_addr;
        pc      <= inc(redirect_addr);
      end else if (state == IDLE) begin
        if (start) begin
          state   <= RUN;
          s1_v    <= 1'b1;
          rd_addr <= start_addr;
          pc      <= inc(start_addr);
        end
      end else begin
        if (cap && cnt_ap == 2'd0) begin
          instr_data <= rd_data;
          instr_pc   <= s2_pc;
        end else if (pop) begin
          instr_data <= b1_data;
          instr_pc   <= b1_pc;
        end
        if (cap && cnt_ap == 2'd1) begin
          b1_data <= rd_data;
          b1_pc   <= s2_pc;
        end
        cnt  <= cnt_ap + {1'b0, cap};
        s2_v <= ~halt & (s1_v | (s2_v & ~cap));
        if (s1_v) s2_pc <= rd_addr;
        s1_v <= issue;
        if (issue) begin
          rd_addr <= pc;
          pc      <= inc(pc);
        end
        if (halt) begin
          state <= DRAIN;
        end else if (state == DRAIN && pop &&
                     cnt == 2'd1) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating accept/stall counters, cleared when a program starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      stall_count <= '0;
    end else if (state == IDLE && start && !stop) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop && instr_count != '1)
        instr_count <= instr_count + 32'd1;
      if (instr_valid && !instr_ready && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed program tests plus random stimulus
// checked every cycle against a transaction-level fetch model.
module tb_instr_fetch_unit;
  localparam int IW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          stop = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          busy;
  logic          done;
  logic [31:0]   instr_count;
  logic [31:0]   stall_count;

  logic [IW-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .start_addr(start_addr),
    .stop(stop),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .busy(busy), .done(done),
    .instr_count(instr_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: expected delivery order, busy, done and counters.
  bit            m_busy = 0;
  bit            exp_done = 0;
  bit            flush_exp = 0;
  bit            hold_v = 0;
  bit            is_halt;
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] hold_pc;
  logic [IW-1:0] hold_data;
  int unsigned   m_ic = 0;
  int unsigned   m_sc = 0;
  int            pops = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy    = 0;
      exp_done  = 0;
      flush_exp = 0;
      hold_v    = 0;
      m_ic      = 0;
      m_sc      = 0;
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, exp_done);
      if (!m_busy) chk("idle_valid", instr_valid, 0);
      if (flush_exp) chk("flush_valid", instr_valid, 0);
      if (hold_v) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_pc", instr_pc, hold_pc);
        chk("hold_data", instr_data, hold_data);
      end
`ifdef IFU_PERF_CNT_EN
      chk("instr_count", instr_count, m_ic);
      chk("stall_count", stall_count, m_sc);
`else
      chk("instr_count_zero", instr_count, 0);
      chk("stall_count_zero", stall_count, 0);
`endif
      exp_done  = 0;
      flush_exp = 0;
      hold_v    = 0;
      is_halt   = 0;
      if (instr_valid && instr_ready) begin
        chk("pop_pc", instr_pc, m_pc);
        chk("pop_data", instr_data, mem[m_pc]);
        is_halt = (mem[m_pc][IW-1 -: 6] == 6'h3F);
        m_pc = AW'((int'(m_pc) + 1) % DEPTH);
        if (m_ic != 32'hFFFF_FFFF) m_ic++;
        pops++;
      end
      if (instr_valid && !instr_ready &&
          m_sc != 32'hFFFF_FFFF) m_sc++;
      if (stop) begin
        m_busy    = 0;
        flush_exp = 1;
      end else if (redirect_valid && m_busy) begin
        m_pc      = redirect_addr;
        flush_exp = 1;
      end else if (!m_busy && start) begin
        m_busy    = 1;
        m_pc      = start_addr;
        m_ic      = 0;
        m_sc      = 0;
        flush_exp = 1;
      end else if (is_halt) begin
        m_busy   = 0;
        exp_done = 1;
      end else if (instr_valid && !instr_ready) begin
        hold_v    = 1;
        hold_pc   = instr_pc;
        hold_data = instr_data;
      end
    end
  end

  task automatic fill_plain(input logic [IW-1:0] base);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = base + IW'(i);
  endtask

  task automatic load_prog();
    fill_plain(32'h0010_0000);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'hFC00_0000;
  endtask

  task automatic chk_out(input string n,
                         input logic [AW-1:0] p,
                         input logic [IW-1:0] d);
    chk({n, "_valid"}, instr_valid, 1);
    chk({n, "_pc"}, instr_pc, p);
    chk({n, "_data"}, instr_data, d);
  endtask

  initial begin
    fill_plain(32'h0010_0000);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_icnt", instr_count, 0);
    chk("rst_scnt", stall_count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Program run with ready held high.
    load_prog();
    instr_ready = 1'b1;
    start_addr  = '0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_rd_addr", rd_addr, 0);
    chk("t1_e0_valid", instr_valid, 0);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_e1_valid", instr_valid, 0);
    cyc();
    chk_out("t1_w0", 8'd0, 32'h11);
    cyc();
    chk_out("t1_w1", 8'd1, 32'h22);
    cyc();
    chk_out("t1_w2", 8'd2, 32'h33);
    cyc();
    chk_out("t1_w3", 8'd3, 32'hFC00_0000);
    cyc();
    chk("t1_end_valid", instr_valid, 0);
    chk("t1_done", done, 1);
    chk("t1_end_busy", busy, 0);
    cyc();
    chk("t1_done_pulse", done, 0);

    // Same program with ready 1,0,0,1.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk_out("t2_w0", 8'd0, 32'h11);
    cyc();
    instr_ready = 1'b0;
    chk_out("t2_w1", 8'd1, 32'h22);
    cyc();
    chk_out("t2_stall1", 8'd1, 32'h22);
    cyc();
    chk_out("t2_stall2", 8'd1, 32'h22);
    instr_ready = 1'b1;
    cyc();
    chk_out("t2_w2", 8'd2, 32'h33);
    cyc();
    chk_out("t2_w3", 8'd3, 32'hFC00_0000);
    cyc();
    chk("t2_done", done, 1);
`ifdef IFU_PERF_CNT_EN
    chk("t2_stall_count", stall_count, 2);
    chk("t2_instr_count", instr_count, 4);
`endif

    // Redirect with two words buffered.
    fill_plain(32'h00A0_0000);
    instr_ready = 1'b0;
    start_addr  = 8'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk_out("t3_buf", 8'd2, 32'h00A0_0002);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_flush", instr_valid, 0);
    cyc();
    chk("t3_e1_valid", instr_valid, 0);
    cyc();
    chk_out("t3_r0", 8'h40, 32'h00A0_0040);
    instr_ready = 1'b1;
    cyc();
    chk_out("t3_r1", 8'h41, 32'h00A0_0041);
    cyc();
    chk_out("t3_r2", 8'h42, 32'h00A0_0042);

    // Stop mid-run while stalled.
    instr_ready = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_valid", instr_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    cyc();
    chk("t5_valid2", instr_valid, 0);
    chk("t5_done2", done, 0);

    // PC wrap from the top of memory.
    instr_ready = 1'b1;
    start_addr  = 8'd254;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk_out("t4_254", 8'd254, 32'h00A0_00FE);
    cyc();
    chk_out("t4_255", 8'd255, 32'h00A0_00FF);
    cyc();
    chk_out("t4_0", 8'd0, 32'h00A0_0000);
    cyc();
    chk_out("t4_1", 8'd1, 32'h00A0_0001);

    // Asynchronous reset mid-run.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rd_addr", rd_addr, 0);
    chk("ar_valid", instr_valid, 0);
    chk("ar_data", instr_data, 0);
    chk("ar_pc", instr_pc, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_icnt", instr_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Random programs, back-pressure and control events.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 15) == 0)
        mem[i][IW-1 -: 6] = 6'h3F;
    end
    pops = 0;
    for (int c = 0; c < 4000; c++) begin
      start          = ($urandom_range(0, 7) == 0);
      start_addr     = AW'($urandom);
      stop           = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_addr  = AW'($urandom);
      instr_ready    = ($urandom_range(0, 3) != 0);
      cyc();
    end
    start          = 1'b0;
    stop           = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (20) cyc();
    chk("random_progress", pops > 200, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
